alarm_trigger: RTL and testbench

//  Alarm-time controller that sits directly upstream of alert_counter.
//  - Holds a programmable alarm time and compares it against the running time-of-day.
//  - Drives alert_counter's enable input (alert_en) while the alarm rings.
//  - Handles the stop, snooze and arm/disarm buttons.
//  - Consumes alert_off from alert_counter to end an unattended ring.

---
 rtl/alarm_pkg.sv | 26 ++
 rtl/alarm_trigger_if.sv | 37 +++
 rtl/alarm_trigger_btn_edge.sv | 19 +
 rtl/alarm_trigger.sv | 115 +++++++++++
 tb/tb_alarm_trigger.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Alarm controller shared types: state encoding, time-field widths and limits.
// Imported by the interface, the edge detector and the top-level FSM.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_e;

  function automatic logic time_ok(
    input logic [HOUR_W-1:0] h,
    input logic [MIN_W-1:0]  m
  );
    return (h <= HOUR_MAX) && (m <= MIN_MAX);
  endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// Bundle between the clock front-end/buttons and the alarm controller,
// including the alert_counter enable/timeout pair.
interface alarm_trigger_if;
  import alarm_pkg::*;

  logic              tick_1hz;
  logic [HOUR_W-1:0] cur_hour;
  logic [MIN_W-1:0]  cur_min;
  logic [SEC_W-1:0]  cur_sec;
  logic [HOUR_W-1:0] set_hour;
  logic [MIN_W-1:0]  set_min;
  logic              alarm_set;
  logic              arm_btn;
  logic              snooze_btn;
  logic              stop_btn;
  logic              alert_off;
  logic              alert_en;
  logic              armed;
  logic              snoozing;
  logic [1:0]        snooze_cnt;
  logic              missed;

  modport master (
    output tick_1hz, cur_hour, cur_min, cur_sec,
    output set_hour, set_min, alarm_set,
    output arm_btn, snooze_btn, stop_btn, alert_off,
    input  alert_en, armed, snoozing, snooze_cnt, missed
  );

  modport slave (
    input  tick_1hz, cur_hour, cur_min, cur_sec,
    input  set_hour, set_min, alarm_set,
    input  arm_btn, snooze_btn, stop_btn, alert_off,
    output alert_en, armed, snoozing, snooze_cnt, missed
  );

endinterface

// File: rtl/alarm_trigger_btn_edge.sv
// Rising-edge detector for an already-synchronised level button.
// The edge is combinational so the FSM acts on the same clock.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic edge_o
);

  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_q <= 1'b0;
    else        dly_q <= btn_i;
  end

  assign edge_o = btn_i & ~dly_q;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm-time controller feeding alert_counter: time match, ring,
// snooze with bounded count, stop, arm toggle and missed-alarm flag.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3,
  parameter int TMR_W      = 9
) (
  input logic      clk,
  input logic      rst_n,
  alarm_trigger_if.slave bus
);

  logic set_e, arm_e, snz_e, stop_e;

  btn_edge u_set  (.clk(clk), .rst_n(rst_n),
                   .btn_i(bus.alarm_set), .edge_o(set_e));
  btn_edge u_arm  (.clk(clk), .rst_n(rst_n),
                   .btn_i(bus.arm_btn), .edge_o(arm_e));
  btn_edge u_snz  (.clk(clk), .rst_n(rst_n),
                   .btn_i(bus.snooze_btn), .edge_o(snz_e));
  btn_edge u_stop (.clk(clk), .rst_n(rst_n),
                   .btn_i(bus.stop_btn), .edge_o(stop_e));

  logic [HOUR_W-1:0] alm_hour_q;
  logic [MIN_W-1:0]  alm_min_q;
  state_e            state_q;
  logic [TMR_W-1:0]  timer_q;
  logic [1:0]        cnt_q;
  logic              missed_q;
  logic              match;
  logic              snz_ok;

  assign match = bus.tick_1hz
              && (bus.cur_hour == alm_hour_q)
              && (bus.cur_min == alm_min_q)
              && (bus.cur_sec == '0);

  assign snz_ok = cnt_q < 2'(MAX_SNOOZE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alm_hour_q <= '0;
      alm_min_q  <= '0;
    end else if (set_e && time_ok(bus.set_hour, bus.set_min)) begin
      alm_hour_q <= bus.set_hour;
      alm_min_q  <= bus.set_min;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      cnt_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      if (arm_e || stop_e) missed_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm_e) state_q <= ARMED;
        end
        ARMED: begin
          if (arm_e)      state_q <= IDLE;
          else if (match) state_q <= RINGING;
        end
        RINGING: begin
          if (arm_e) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (stop_e) begin
            state_q <= ARMED;
            cnt_q   <= '0;
          end else if (bus.alert_off) begin
            state_q  <= ARMED;
            cnt_q    <= '0;
            missed_q <= 1'b1;
          end else if (snz_e && snz_ok) begin
            state_q <= SNOOZE;
            timer_q <= TMR_W'(SNOOZE_SEC);
            cnt_q   <= cnt_q + 2'd1;
          end
        end
        SNOOZE: begin
          if (arm_e) begin
            state_q <= IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
          end else if (stop_e) begin
            state_q <= ARMED;
            timer_q <= '0;
            cnt_q   <= '0;
          end else if (bus.tick_1hz) begin
            // Last tick of the snooze window restarts the ring
            if (timer_q == TMR_W'(1)) begin
              state_q <= RINGING;
              timer_q <= '0;
            end else begin
              timer_q <= timer_q - TMR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.alert_en   = (state_q == RINGING);
  assign bus.armed      = (state_q != IDLE);
  assign bus.snoozing   = (state_q == SNOOZE);
  assign bus.snooze_cnt = cnt_q;
  assign bus.missed     = missed_q;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger with a queue-based scoreboard;
// expectations are pushed by the stimulus and checked at negedge.
module tb_alarm_trigger;
  import alarm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alarm_trigger_if bus();

  alarm_trigger #(
    .SNOOZE_SEC(5),
    .MAX_SNOOZE(3),
    .TMR_W(9)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  typedef struct {
    string      tag;
    logic       en;
    logic       arm;
    logic       snz;
    logic [1:0] cnt;
    logic       mis;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [1:0] act,
                     input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".alert_en"}, {1'b0, bus.alert_en}, {1'b0, e.en});
      chk({e.tag, ".armed"}, {1'b0, bus.armed}, {1'b0, e.arm});
      chk({e.tag, ".snoozing"}, {1'b0, bus.snoozing}, {1'b0, e.snz});
      chk({e.tag, ".snooze_cnt"}, bus.snooze_cnt, e.cnt);
      chk({e.tag, ".missed"}, {1'b0, bus.missed}, {1'b0, e.mis});
    end
  end

  task automatic push(input string tag, input logic en, input logic arm,
                      input logic snz, input logic [1:0] cnt,
                      input logic mis);
    exp_t e;
    e.tag = tag;
    e.en  = en;
    e.arm = arm;
    e.snz = snz;
    e.cnt = cnt;
    e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    bus.tick_1hz   = 1'b0;
    bus.alarm_set  = 1'b0;
    bus.arm_btn    = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.alert_off  = 1'b0;
  endtask

  task automatic go();
    cyc();
    clear_strobes();
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.cur_hour = 5'(h);
    bus.cur_min  = 6'(m);
    bus.cur_sec  = 6'(s);
  endtask

  task automatic tick();
    bus.tick_1hz = 1'b1;
    go();
  endtask

  // Idle cycle first so the delayed button copy has seen a low level
  task automatic press(input bit a, input bit sn, input bit st,
                       input bit ld, input bit off);
    cyc();
    bus.arm_btn    = a;
    bus.snooze_btn = sn;
    bus.stop_btn   = st;
    bus.alarm_set  = ld;
    bus.alert_off  = off;
    go();
  endtask

  task automatic snooze_wait(input logic [1:0] cnt);
    for (int i = 1; i <= 4; i++) begin
      tick();
      push("snz_wait", 1'b0, 1'b1, 1'b1, cnt, 1'b0);
      go();
      push("snz_idle", 1'b0, 1'b1, 1'b1, cnt, 1'b0);
    end
    tick();
    push("resume", 1'b1, 1'b1, 1'b0, cnt, 1'b0);
  endtask

  initial begin
    clear_strobes();
    set_time(12, 0, 5);
    bus.set_hour = '0;
    bus.set_min  = '0;
    rst_n = 1'b0;
    cyc();
    push("reset", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc();
    rst_n = 1'b1;

    press(1, 0, 0, 0, 0);
    push("arm", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    bus.set_hour = 5'd7;
    bus.set_min  = 6'd30;
    press(0, 0, 0, 1, 0);
    push("load", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    set_time(7, 30, 0);
    go();
    push("no_tick", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    push("ring", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    set_time(7, 30, 1);

    press(0, 1, 0, 0, 0);
    push("snz1", 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    snooze_wait(2'd1);
    press(0, 1, 0, 0, 0);
    push("snz2", 1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
    snooze_wait(2'd2);
    press(0, 1, 0, 0, 0);
    push("snz3", 1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
    snooze_wait(2'd3);
    press(0, 1, 0, 0, 0);
    push("snz4_ignored", 1'b1, 1'b1, 1'b0, 2'd3, 1'b0);

    press(0, 1, 1, 0, 0);
    push("stop_snz", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    set_time(7, 30, 0);
    tick();
    push("ring2", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    press(0, 0, 0, 0, 1);
    push("timeout", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    press(1, 0, 0, 0, 0);
    push("arm_clr", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    bus.set_hour = 5'd24;
    bus.set_min  = 6'd15;
    press(0, 0, 0, 1, 0);
    push("bad_hour", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    bus.set_hour = 5'd8;
    bus.set_min  = 6'd60;
    press(0, 0, 0, 1, 0);
    push("bad_min", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    press(1, 0, 0, 0, 0);
    push("rearm", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    set_time(8, 0, 0);
    tick();
    push("no_match_0800", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    set_time(7, 30, 0);
    tick();
    push("ring3", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    press(0, 0, 1, 0, 1);
    push("stop_off", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);

    tick();
    push("ring4", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    press(0, 1, 0, 0, 0);
    push("snz_again", 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    tick();
    push("snz_match_ign", 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc();
    rst_n = 1'b0;
    #1;
    push("rst_mid", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;

    press(1, 0, 0, 0, 0);
    push("arm_after_rst", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    tick();
    push("ring_00", 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    set_time(0, 0, 0);
    tick();
    push("ring_rst_alm", 1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
    press(1, 1, 1, 0, 1);
    push("arm_wins", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

    cyc();
    cyc();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
